// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one 1-bit full adder stepped LSB-first
// through a registered carry, with start/busy/done handshake.
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cmsb_q, cmsb_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [1:0]       fa;
  logic             s_bit;
  logic             c_next;

  // The single shared full-adder cell.
  assign fa     = {1'b0, a_sr_q[0]} + {1'b0, b_sr_q[0]} + {1'b0, carry_q};
  assign s_bit  = fa[0];
  assign c_next = fa[1];

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cmsb_d  = cmsb_q;
    busy_d  = busy_q;
    done_d  = done_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
        if (start) begin
          // Subtraction as a + ~b + 1, the +1 entering as the initial carry.
          a_sr_d  = a;
          b_sr_d  = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        res_d   = {s_bit, res_q[WIDTH-1:1]};
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        carry_d = c_next;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 2)) cmsb_d = c_next;
        if (cnt_q == CW'(WIDTH - 1)) begin
          cout_d  = c_next;
          ovf_d   = cmsb_q ^ c_next;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cmsb_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cmsb_q  <= cmsb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = res_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random checks of serial_add_ctrl against an arithmetic model.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start, sub;
  logic [W-1:0] a, b;
  logic         busy, done, cout, ovf;
  logic [W-1:0] result;

  int errors = 0;
  int checks = 0;

  serial_add_ctrl #(.WIDTH(W), .CW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, unsigned for carry, signed for overflow.
  function automatic logic [9:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    int sx, sy, tr;
    logic [W-1:0] r;
    logic c, o;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (s) begin
      r  = x - y;
      c  = (x >= y);
      tr = sx - sy;
    end else begin
      r  = x + y;
      c  = (int'(x) + int'(y)) > 255;
      tr = sx + sy;
    end
    o = (tr > 127) || (tr < -128);
    return {c, o, r};
  endfunction

  // Called at a negedge with start driven; returns at the negedge showing done.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts,
                        input int stray_at, input string tag);
    logic [9:0] exp;
    int waits, busy_cnt;
    exp = model(ta, tb_, ts);
    a = ta; b = tb_; sub = ts; start = 1'b1;
    @(posedge clk);
    waits = 0; busy_cnt = 0;
    while (waits < 40) begin
      @(negedge clk);
      waits++;
      start = (waits == stray_at);
      a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
      if (busy) busy_cnt++;
      if (waits == 1) check({tag, "_done_low_after_accept"}, 32'(done), 32'd0);
      if (done) break;
    end
    check({tag, "_latency"}, waits, W + 1);
    check({tag, "_busy_cycles"}, busy_cnt, W);
    check({tag, "_result"}, 32'(result), 32'(exp[7:0]));
    check({tag, "_cout"}, 32'(cout), 32'(exp[9]));
    check({tag, "_ovf"}, 32'(ovf), 32'(exp[8]));
  endtask

  task automatic idle_after(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts,
                            input string tag);
    logic [9:0] exp;
    exp = model(ta, tb_, ts);
    start = 1'b0;
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    check({tag, "_result_held"}, 32'(result), 32'(exp[7:0]));
    check({tag, "_ovf_held"}, 32'(ovf), 32'(exp[8]));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    check("reset_cout", 32'(cout), 32'd0);
    check("reset_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(8'h35, 8'h4A, 1'b0, 0, "add_35_4a");
    check("add_35_4a_abs", 32'(result), 32'h7F);
    idle_after(8'h35, 8'h4A, 1'b0, "add_35_4a");

    run_op(8'hFF, 8'h01, 1'b0, 0, "add_ff_01");
    idle_after(8'hFF, 8'h01, 1'b0, "add_ff_01");
    run_op(8'h7F, 8'h01, 1'b0, 0, "add_7f_01");
    check("add_7f_01_ovf_abs", 32'(ovf), 32'd1);
    idle_after(8'h7F, 8'h01, 1'b0, "add_7f_01");
    run_op(8'h10, 8'h20, 1'b1, 0, "sub_10_20");
    check("sub_10_20_abs", 32'(result), 32'hF0);
    idle_after(8'h10, 8'h20, 1'b1, "sub_10_20");
    run_op(8'h80, 8'h01, 1'b1, 0, "sub_80_01");
    check("sub_80_01_cout_abs", 32'(cout), 32'd1);
    idle_after(8'h80, 8'h01, 1'b1, "sub_80_01");

    // Start pulsed mid-operation must be ignored.
    run_op(8'h12, 8'h34, 1'b0, 3, "stray_start");
    idle_after(8'h12, 8'h34, 1'b0, "stray_start");
    check("stray_start_stays_idle", 32'(busy), 32'd0);

    // Back-to-back: next start issued during the done cycle.
    run_op(8'h55, 8'h66, 1'b1, 0, "b2b_first");
    run_op(8'h01, 8'h02, 1'b0, 0, "b2b_second");
    check("b2b_second_abs", 32'(result), 32'h03);
    idle_after(8'h01, 8'h02, 1'b0, "b2b_second");

    // Reset aborts mid-operation with no done pulse.
    a = 8'hA5; b = 8'h5A; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    check("abort_ovf", 32'(ovf), 32'd0);
    begin
      int seen;
      seen = 0;
      repeat (12) begin
        @(negedge clk);
        if (done || busy) seen++;
      end
      check("abort_no_done_pulse", seen, 0);
    end
    run_op(8'hC3, 8'h3C, 1'b1, 0, "after_abort");
    idle_after(8'hC3, 8'h3C, 1'b1, "after_abort");

    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] ra, rb;
      logic rs;
      ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom);
      run_op(ra, rb, rs, 0, "random");
      idle_after(ra, rb, rs, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
